// File: rtl/bus_resp_mux.sv
// Read-response return stage: tracks one outstanding request, waits for the
// selected slave's ready and returns its data (or an error) as a one-cycle pulse.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req, sel[1:0]             request strobe and decoder slave select
//   sN_rdata, sN_ready        slave read data / data-valid, N = 1..3
//   m_rdata, m_valid, m_err   registered response to the master
//   busy                      request outstanding (WAIT or ERR)
//
// Optional feature: define RESP_TIMEOUT_EN to force an error response after
// TIMEOUT WAIT cycles without the selected slave becoming ready.
module bus_resp_mux #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] s1_rdata,
   input  logic [DATA_W-1:0] s2_rdata,
   input  logic [DATA_W-1:0] s3_rdata,
   input  logic              s1_ready,
   input  logic              s2_ready,
   input  logic              s3_ready,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_valid,
   output logic              m_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        sel_q, sel_q_nxt;
   logic [DATA_W-1:0] rdata_nxt;
   logic              valid_nxt;
   logic              err_nxt;
   logic              sel_ready;
   logic [DATA_W-1:0] sel_rdata;

   // Counter range is 8 bits, so TIMEOUT must fit in 1..255.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_resp_mux: TIMEOUT out of range 1..255");
   end

`ifdef RESP_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt, cnt_nxt;
`endif

   // Only the slave latched at request time is observed.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      unique case (sel_q)
         2'b01: begin
            sel_ready = s1_ready;
            sel_rdata = s1_rdata;
         end
         2'b10: begin
            sel_ready = s2_ready;
            sel_rdata = s2_rdata;
         end
         2'b11: begin
            sel_ready = s3_ready;
            sel_rdata = s3_rdata;
         end
         default: begin
            sel_ready = 1'b0;
            sel_rdata = '0;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      sel_q_nxt = sel_q;
      rdata_nxt = m_rdata;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
`ifdef RESP_TIMEOUT_EN
      cnt_nxt   = cnt;
`endif
      unique case (state)
         IDLE: begin
            if (req) begin
               if (sel == 2'b00) begin
                  state_nxt = ERR;
               end else begin
                  sel_q_nxt = sel;
                  state_nxt = WAIT;
`ifdef RESP_TIMEOUT_EN
                  cnt_nxt   = '0;
`endif
               end
            end
         end
         WAIT: begin
            // Ready in the last counted cycle still wins over the timeout.
            if (sel_ready) begin
               rdata_nxt = sel_rdata;
               valid_nxt = 1'b1;
               state_nxt = IDLE;
            end
`ifdef RESP_TIMEOUT_EN
            else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
`endif
         end
         ERR: begin
            rdata_nxt = '0;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel_q   <= 2'b00;
         m_rdata <= '0;
         m_valid <= 1'b0;
         m_err   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
         cnt     <= '0;
`endif
      end else begin
         state   <= state_nxt;
         sel_q   <= sel_q_nxt;
         m_rdata <= rdata_nxt;
         m_valid <= valid_nxt;
         m_err   <= err_nxt;
`ifdef RESP_TIMEOUT_EN
         cnt     <= cnt_nxt;
`endif
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_resp_mux.sv
// Scoreboard bench for bus_resp_mux: expected responses are queued with the
// cycle they must appear in and matched against m_valid pulses.
module tb_bus_resp_mux;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic [1:0]    sel;
   logic [DW-1:0] s1_rdata, s2_rdata, s3_rdata;
   logic          s1_ready, s2_ready, s3_ready;
   logic [DW-1:0] m_rdata;
   logic          m_valid, m_err, busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int            at;
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   exp_t q[$];

   bus_resp_mux #(.DATA_W(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req(req), .sel(sel),
      .s1_rdata(s1_rdata), .s2_rdata(s2_rdata), .s3_rdata(s3_rdata),
      .s1_ready(s1_ready), .s2_ready(s2_ready), .s3_ready(s3_ready),
      .m_rdata(m_rdata), .m_valid(m_valid), .m_err(m_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int at, input logic e, input logic [DW-1:0] d);
      exp_t x;
      x.at   = at;
      x.err  = e;
      x.data = d;
      q.push_back(x);
   endtask

   // Response monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].at < cyc) begin
         chk("missing_resp", cyc, q[0].at);
         void'(q.pop_front());
      end
      if (m_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t x;
            x = q.pop_front();
            chk("resp_cycle", cyc, x.at);
            chk("resp_err", int'(m_err), int'(x.err));
            chk("resp_data", int'(m_rdata), int'(x.data));
         end
      end
   end

   task automatic idle_inputs();
      req = 0; sel = 0;
      s1_ready = 0; s2_ready = 0; s3_ready = 0;
   endtask

   // Mapped read with ready after d WAIT cycles (d >= 1).
   task automatic read(input logic [1:0] s, input int d, input logic [DW-1:0] v);
      int c;
      c = cyc;
      req = 1; sel = s;
      case (s)
         2'b01: s1_rdata = v;
         2'b10: s2_rdata = v;
         default: s3_rdata = v;
      endcase
      tick();
      req = 0; sel = 2'($urandom);
      repeat (d - 1) tick();
      case (s)
         2'b01: s1_ready = 1;
         2'b10: s2_ready = 1;
         default: s3_ready = 1;
      endcase
      push(c + d + 1, 1'b0, v);
      tick();
      idle_inputs();
      tick();
   endtask

   initial begin
      int c;
      rst = 1;
      req = 1'($urandom); sel = 2'($urandom);
      s1_rdata = 8'($urandom); s2_rdata = 8'($urandom); s3_rdata = 8'($urandom);
      s1_ready = 1; s2_ready = 1; s3_ready = 1;
      tick();
      req = 1'($urandom); sel = 2'($urandom);
      tick();
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_err", int'(m_err), 0);
      chk("rst_rdata", int'(m_rdata), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 0;
      idle_inputs();
      tick();

      // Slave2 with stray s1/s3 ready pulses during WAIT.
      c = cyc;
      req = 1; sel = 2'b10; s2_rdata = 8'hA5;
      tick();
      req = 0; sel = 2'b01;
      chk("s2_busy_rise", int'(busy), 1);
      s1_ready = 1; s3_ready = 1;
      tick();
      s1_ready = 0;
      tick();
      s3_ready = 0; s2_ready = 1;
      push(c + 4, 1'b0, 8'hA5);
      tick();
      s2_ready = 0;
      chk("s2_busy_fall", int'(busy), 0);
      tick();

      // Unmapped: busy exactly one cycle.
      c = cyc;
      req = 1; sel = 2'b00;
      push(c + 2, 1'b1, 8'h00);
      tick();
      req = 0;
      chk("unm_busy1", int'(busy), 1);
      tick();
      chk("unm_busy2", int'(busy), 0);
      tick();

      // Second req while busy ignored; req in m_valid cycle accepted.
      c = cyc;
      req = 1; sel = 2'b01; s1_rdata = 8'h77;
      tick();
      req = 1; sel = 2'b11; s3_rdata = 8'hEE;
      tick();
      req = 0;
      s1_ready = 1;
      push(c + 3, 1'b0, 8'h77);
      tick();
      s1_ready = 0;
      req = 1; sel = 2'b11; s3_rdata = 8'h11;
      tick();
      req = 0;
      chk("b2b_busy", int'(busy), 1);
      s3_ready = 1;
      push(c + 5, 1'b0, 8'h11);
      tick();
      idle_inputs();
      repeat (3) tick();
      chk("rdata_hold", int'(m_rdata), 8'h11);

      // Reset in WAIT cycle 2 discards the request.
      req = 1; sel = 2'b11; s3_rdata = 8'h5A;
      tick();
      req = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      s3_ready = 1;
      chk("rstw_busy", int'(busy), 0);
      chk("rstw_rdata", int'(m_rdata), 0);
      tick();
      chk("rstw_busy2", int'(busy), 0);
      chk("rstw_valid", int'(m_valid), 0);
      tick();
      s3_ready = 0;
      tick();

`ifdef RESP_TIMEOUT_EN
      c = cyc;
      req = 1; sel = 2'b01;
      push(c + 6, 1'b1, 8'h00);
      tick();
      req = 0;
      repeat (4) tick();
      chk("to_busy_err", int'(busy), 1);
      tick();
      chk("to_busy_end", int'(busy), 0);
      tick();
      read(2'b01, 4, 8'h3C);
`else
      read(2'b01, 20, 8'h3C);
`endif

      for (int i = 0; i < 9; i++) begin
         read(2'(i % 3 + 1), int'($urandom_range(1, 3)), 8'($urandom));
      end

      repeat (4) tick();
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim did not finish");
      $fatal(1);
   end

endmodule

// File: doc/bus_resp_mux.md
# bus_resp_mux

Read-response return stage of the system bus, directly downstream of the address decoder. It takes the decoder's registered 2-bit slave select, tracks one outstanding master request, waits for the selected slave's ready, and returns that slave's read data to the master as a registered one-cycle response. Requests to unmapped space (select 2'b00) and, optionally, slaves that never answer are terminated with an error response, so the master never hangs.

## Interface
- DATA_W, 8, read data width for all slaves and the master.
- TIMEOUT, 15, WAIT-state cycles before an error is forced; legal range 1..255.

- clk  input  1  bus clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  master request strobe; one cycle, aligned with the cycle `sel` is valid (decoder output).
- sel  input  2  decoder slave select: 00 unmapped, 01 slave1 (2K), 10 slave2 (4K), 11 slave3 (4K).
- s1_rdata / s2_rdata / s3_rdata  input  DATA_W  slave read data.
- s1_ready / s2_ready / s3_ready  input  1  slave data-valid, level-sampled.
- m_rdata  output  DATA_W  returned read data, registered.
- m_valid  output  1  one-cycle response pulse.
- m_err  output  1  error flag, valid only with m_valid.
- busy  output  1  high while a request is outstanding (state WAIT or ERR).

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, WAIT, ERR.
- IDLE: on req with sel==00 -> ERR. On req with sel!=00 -> latch sel into sel_q, clear timeout counter, -> WAIT. No req -> stay. Slave ready inputs ignored in IDLE.
- WAIT: only the ready/rdata of the slave named by sel_q is observed; other slaves' ready ignored. Selected ready=1 -> m_rdata<=selected rdata, m_valid<=1, m_err<=0, -> IDLE. Otherwise counter increments.
- ERR: single cycle; m_valid<=1, m_err<=1, m_rdata<=0, -> IDLE.
- req while busy=1 is ignored (not queued); upstream must not issue while busy.
- sel changes after the req cycle have no effect (sel_q is used).
- Counter width 8 bits; unsigned; saturates never needed since exit occurs at TIMEOUT.

## Timing
- Reset values: m_rdata=0, m_valid=0, m_err=0, busy=0, state IDLE, sel_q=00, counter=0.
- rst high mid-request: next edge returns to IDLE, in-flight response discarded, no m_valid emitted; slave ready arriving after reset ignored.
- Mapped read: req at cycle N, ready first sampled in cycle N+1; ready high in cycle K (K>=N+1) -> m_valid/m_rdata at K+1. Minimum latency req->m_valid = 2 cycles.
- Unmapped read: req at N -> ERR in N+1 -> m_valid=1, m_err=1 visible at N+2... precisely: registered outputs update at edge ending N+1, i.e. visible in cycle N+2; busy=1 in cycle N+1.
- busy rises the cycle after req and falls in the same cycle m_valid is high.
- m_valid is high exactly one cycle per accepted request; new req may be accepted in the m_valid cycle (state is IDLE).
- m_rdata holds its value after m_valid until the next response.

## Configuration
- RESP_TIMEOUT_EN defined: in WAIT, when counter reaches TIMEOUT-1 with selected ready still low, -> ERR (error response TIMEOUT+1 cycles after entering WAIT is visible). Ready high in the final counted cycle wins: data returned, no error.
- RESP_TIMEOUT_EN undefined: no counter; WAIT lasts until the selected slave is ready. Unmapped (sel==00) error path unchanged. TIMEOUT parameter unused.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, busy=0.
- Slave2 read: sel=10, req at N, s2_rdata=8'hA5, s2_ready high at N+3 -> m_valid=1, m_err=0, m_rdata=8'hA5 at N+4; s1/s3 ready pulses during WAIT ignored.
- Unmapped: sel=00, req -> single m_valid with m_err=1, m_rdata=8'h00; busy high exactly one cycle.
- Timeout (RESP_TIMEOUT_EN, TIMEOUT=4): sel=01, s1_ready never asserted -> m_valid=1, m_err=1 after 4 WAIT cycles; same run with s1_ready in 4th WAIT cycle, s1_rdata=8'h3C -> m_rdata=8'h3C, m_err=0.
- Back-to-back/ignored req: second req while busy -> no second response; req in the m_valid cycle to slave3 (s3_rdata=8'h11) -> accepted, returns 8'h11.
- Reset mid-WAIT: sel=11, req, rst at WAIT cycle 2, then s3_ready high -> no m_valid, state IDLE.
